// File: rtl/aes_pkg.sv
// Shared types and byte-addressing helpers for the AES round datapath.
// A state is 16 bytes in column-major order; byte 0 sits in the top bits.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  typedef logic [AES_STATE_W-1:0] aes_state_t;

  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } sr_mode_t;

  function automatic int row_col_to_byte(input int row, input int col);
    return col * 4 + row;
  endfunction

  // Column that feeds (row, col) after the shift; row 0 always maps to itself.
  function automatic int sr_src_col(input int row, input int col, input logic inv);
    return inv ? (col - row + 4) % 4 : (col + row) % 4;
  endfunction

endpackage

// File: rtl/aes_shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows for a single 128-bit AES state.
// The shift is pure wiring; mode only selects which rotation is applied.
module aes_shift_rows_core
  import aes_pkg::*;
(
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   mode,
  output logic [AES_STATE_W-1:0] state_out
);

  always_comb begin
    state_out = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        state_out[AES_STATE_W-1-8*row_col_to_byte(row, col) -: 8] =
          state_in[AES_STATE_W-1-8*row_col_to_byte(row, sr_src_col(row, col, mode == SR_INV)) -: 8];
      end
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows stage: transforms LANES states on write and buffers the
// results, tag and mode in a DEPTH-entry FIFO so neighbouring stages can stall.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// in_ready depends only on occupancy (never on out_ready); the producer holds its
// inputs until accepted and the head outputs stay stable until popped.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_mode,
  input  logic [LANES*AES_STATE_W-1:0]   in_data,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*AES_STATE_W-1:0]   out_data,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           out_mode,
  output logic [$clog2(DEPTH):0]         occupancy,
  output logic [15:0]                    xfer_count
);

  localparam int DW    = LANES * AES_STATE_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [DW-1:0]    r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic             r_mem_mode [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [15:0]      r_xfer;

  logic [DW-1:0]    w_xf;
  logic             w_push;
  logic             w_pop;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    aes_shift_rows_core u_core (
      .state_in  (in_data[k*AES_STATE_W +: AES_STATE_W]),
      .mode      (in_mode),
      .state_out (w_xf[k*AES_STATE_W +: AES_STATE_W])
    );
  end

  assign in_ready  = (r_occ < OCC_FULL);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_xf;
      r_mem_tag[r_wr_ptr]  <= in_tag;
      r_mem_mode[r_wr_ptr] <= in_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_xfer   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_xfer   <= r_xfer + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_tag    = out_valid ? r_mem_tag[r_rd_ptr]  : '0;
  assign out_mode   = out_valid ? r_mem_mode[r_rd_ptr] : 1'b0;
  assign occupancy  = r_occ;
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Bench for aes_shift_rows_pipe: known-answer vectors, backpressure, streaming,
// mid-stream reset and randomized forward/inverse round trips.
module tb_aes_shift_rows_pipe;

  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int DW    = LANES * 128;
  localparam int W     = DW + TAG_W + 1;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  localparam logic [127:0] KAT0_IN  = 128'hDB5C77AA2BD6040C51AC0A3DF41C4507;
  localparam logic [127:0] KAT0_OUT = 128'hDB1C0A0C2B5C453D51D67707F4AC04AA;
  localparam logic [127:0] KAT1_IN  = 128'hF76B38416DF88A09B0E52267E8C6BB6E;
  localparam logic [127:0] KAT1_OUT = 128'hF7C622096D6BBB67B0F8386EE8E58A41;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [DW-1:0]    in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_mode;
  logic [OCC_W-1:0] occupancy;
  logic [15:0]      xfer_count;

  aes_shift_rows_pipe #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_mode   (out_mode),
    .occupancy  (occupancy),
    .xfer_count (xfer_count)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [15:0]  exp_xfer;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each row r of the 4x4 byte matrix is rotated left by r (forward)
  // or right by r (inverse).
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4][4];
    logic [7:0]   row_v [4];
    logic [127:0] o;
    int           sh;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = s[127-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) row_v[c] = m[r][c];
      sh = inv ? (4 - r) % 4 : r;
      for (int c = 0; c < 4; c++) m[r][c] = row_v[(c + sh) % 4];
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = m[r][c];
    return o;
  endfunction

  function automatic logic [DW-1:0] ref_lanes(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] o;
    for (int k = 0; k < LANES; k++) o[k*128 +: 128] = ref_sr(d[k*128 +: 128], inv);
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // monitor: compare the head entry whenever it is consumed
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_extra: got unexpected output %h, expected no output",
                 {out_mode, out_tag, out_data});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("scoreboard", {out_mode, out_tag, out_data}, mon_exp);
      end
    end
  end

  // driver: called #1 after a rising edge, returns #1 after the accepting edge
  task automatic push(input logic [DW-1:0] d, input logic m, input logic [TAG_W-1:0] t,
                      input logic [DW-1:0] exp_d, input bit rand_rdy);
    int waited = 0;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    in_valid = 1'b1;
    while (!in_ready) begin
      if (waited >= 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
        in_valid = 1'b0;
        return;
      end
      if (rand_rdy && waited > 0) out_ready = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    exp_q.push_back({m, t, exp_d});
    exp_xfer++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (occupancy != '0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_occupancy", W'(occupancy), W'(0));
    chk("drain_queue", W'(exp_q.size()), W'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_xfer = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]    x;
    logic [DW-1:0]    fx;
    logic [TAG_W-1:0] t;
    int               c0;

    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    exp_xfer  = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_occupancy", W'(occupancy), W'(0));
    chk("reset_xfer_count", W'(xfer_count), W'(0));
    chk("reset_head", {out_mode, out_tag, out_data}, W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // backpressure: fill, ignore a third request, then drain in order
    out_ready = 1'b0;
    push(rand_data(), 1'b0, 4'd1, '0, 1'b0);
    exp_q[exp_q.size()-1] = {1'b0, 4'd1, ref_lanes(in_data, 1'b0)};
    push(rand_data(), 1'b1, 4'd2, '0, 1'b0);
    exp_q[exp_q.size()-1] = {1'b1, 4'd2, ref_lanes(in_data, 1'b1)};
    chk("full_in_ready", W'(in_ready), W'(0));
    chk("full_occupancy", W'(occupancy), W'(2));
    in_data  = rand_data();
    in_tag   = 4'd3;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("full_ignored_xfer", W'(xfer_count), W'(2));
    chk("full_ignored_occ", W'(occupancy), W'(2));
    out_ready = 1'b1;
    chk("full_pop_same_cycle_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    chk("full_pop_next_cycle_ready", W'(in_ready), W'(1));
    chk("full_pop_occupancy", W'(occupancy), W'(1));
    drain();

    // known-answer vectors, both lanes
    out_ready = 1'b1;
    push({KAT1_IN, KAT0_IN}, 1'b1, 4'd5, {KAT1_OUT, KAT0_OUT}, 1'b0);
    chk("kat_inv_latency_valid", W'(out_valid), W'(1));
    chk("kat_inv_lane0", W'(out_data[127:0]), W'(KAT0_OUT));
    chk("kat_inv_lane1", W'(out_data[255:128]), W'(KAT1_OUT));
    push({KAT1_OUT, KAT0_OUT}, 1'b0, 4'd6, {KAT1_IN, KAT0_IN}, 1'b0);
    chk("kat_fwd_lane0", W'(out_data[127:0]), W'(KAT0_IN));
    drain();

    // streaming: one accept per cycle with the consumer always ready
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      x = rand_data();
      push(x, i[0], TAG_W'(i), ref_lanes(x, i[0]), 1'b0);
      chk("stream_occupancy", W'(occupancy), W'(1));
    end
    chk("stream_cycles", W'(cyc - c0), W'(20));
    drain();

    // reset with entries queued
    out_ready = 1'b0;
    x = rand_data();
    push(x, 1'b0, 4'd7, ref_lanes(x, 1'b0), 1'b0);
    push(x, 1'b1, 4'd8, ref_lanes(x, 1'b1), 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_occupancy", W'(occupancy), W'(0));
    chk("midrst_xfer_count", W'(xfer_count), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_head", {out_mode, out_tag, out_data}, W'(0));
    exp_q.delete();
    exp_xfer = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    x = rand_data();
    push(x, 1'b1, 4'd9, ref_lanes(x, 1'b1), 1'b0);
    chk("postrst_valid", W'(out_valid), W'(1));
    chk("postrst_xfer_count", W'(xfer_count), W'(1));
    drain();

    // randomized round trips with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      x  = rand_data();
      fx = ref_lanes(x, 1'b0);
      t  = TAG_W'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      push(x, 1'b0, t, fx, 1'b1);
      out_ready = 1'($urandom_range(0, 1));
      push(fx, 1'b1, t + 1'b1, x, 1'b1);
    end
    drain();
    chk("final_xfer_count", W'(xfer_count), W'(exp_xfer));

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
